// File: rtl/watchdog_supervisor.sv
// -----------------------------------------------------------------------------
// watchdog_supervisor
//
// Collects heartbeats from up to NUM_SRC requesters over fixed windows of
// CHECK_PERIOD cycles. When every enabled requester has beaten during a window,
// it sends one aggregated heartbeat pulse to a downstream watchdog timer. When
// the watchdog fires, the supervisor holds the supervised datapath in reset for
// RECOVER_CYCLES cycles. After MAX_RETRIES recoveries it locks out, and only
// rst clears that state.
//
// Optional feature (macro WDT_SUP_RETRY_DECAY_EN): a run of 8 consecutive
// healthy windows forgives one earlier recovery. When the macro is not
// defined, retry_count only ever goes up until rst, and no streak counter
// exists in the design.
//
// Ports:
//   clk             system clock, all logic on rising edge
//   rst             synchronous active-high reset
//   src_enable      per-requester participation mask
//   src_beat        per-requester heartbeat (pulse or level)
//   wdt_triggered   expiry flag from the downstream watchdog
//   wdt_enable      watchdog enable (high only while supervising)
//   wdt_heartbeat   one-cycle aggregated heartbeat
//   wdt_force_reset force-reset request to the watchdog
//   subsys_reset    reset to the supervised datapath
//   missing_mask    enabled sources absent in the last completed window
//   retry_count     recoveries performed since rst (saturating)
//   lockout         permanent fault indication
// -----------------------------------------------------------------------------
module watchdog_supervisor #(
    parameter int NUM_SRC        = 4,
    parameter int CHECK_PERIOD   = 1000,
    parameter int RECOVER_CYCLES = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_enable,
    input  logic [NUM_SRC-1:0] src_beat,
    input  logic               wdt_triggered,
    output logic               wdt_enable,
    output logic               wdt_heartbeat,
    output logic               wdt_force_reset,
    output logic               subsys_reset,
    output logic [NUM_SRC-1:0] missing_mask,
    output logic [1:0]         retry_count,
    output logic               lockout
);

    localparam int CNT_W = $clog2(CHECK_PERIOD);
    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [NUM_SRC-1:0] seen_q, seen_d;
    logic [NUM_SRC-1:0] missing_q, missing_d;
    logic [1:0]         retry_q, retry_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic               hb_q, hb_d;

    logic win_end;
    logic healthy;
    logic retry_at_max;

    assign win_end      = (period_q == CNT_W'(CHECK_PERIOD - 1));
    // Health uses the registered seen mask only. A beat that arrives on the
    // window-end cycle is carried into the next window.
    assign healthy      = ((seen_q & src_enable) == src_enable);
    assign retry_at_max = (retry_q == 2'(MAX_RETRIES));

`ifdef WDT_SUP_RETRY_DECAY_EN
    logic [2:0] streak_q, streak_d;

    always_ff @(posedge clk) begin
        if (rst) streak_q <= '0;
        else     streak_q <= streak_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            period_q  <= '0;
            seen_q    <= '0;
            missing_q <= '0;
            retry_q   <= '0;
            rec_q     <= '0;
            hb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            seen_q    <= seen_d;
            missing_q <= missing_d;
            retry_q   <= retry_d;
            rec_q     <= rec_d;
            hb_q      <= hb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        seen_d    = seen_q;
        missing_d = missing_q;
        retry_d   = retry_q;
        rec_d     = rec_q;
        hb_d      = 1'b0;
`ifdef WDT_SUP_RETRY_DECAY_EN
        streak_d  = streak_q;
`endif

        case (state_q)
            IDLE: begin
                period_d = '0;
                seen_d   = '0;
                if (|src_enable) state_d = RUN;
            end

            RUN: begin
                // A trigger takes priority over both disable and window end,
                // so a coincident window never produces a heartbeat.
                if (wdt_triggered) begin
`ifdef WDT_SUP_RETRY_DECAY_EN
                    streak_d = '0;
`endif
                    if (!retry_at_max) begin
                        state_d = RECOVER;
                        retry_d = retry_q + 2'd1;   // below max, so no wrap
                        rec_d   = '0;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end else if (~|src_enable) begin
                    state_d = IDLE;
                end else if (win_end) begin
                    period_d = '0;
                    seen_d   = src_beat;
                    if (healthy) begin
                        hb_d      = 1'b1;
                        missing_d = '0;
`ifdef WDT_SUP_RETRY_DECAY_EN
                        if (streak_q == 3'd7) begin
                            streak_d = '0;
                            if (retry_q != 2'd0) retry_d = retry_q - 2'd1;
                        end else begin
                            streak_d = streak_q + 3'd1;
                        end
`endif
                    end else begin
                        missing_d = src_enable & ~seen_q;
`ifdef WDT_SUP_RETRY_DECAY_EN
                        streak_d  = '0;
`endif
                    end
                end else begin
                    period_d = period_q + CNT_W'(1);
                    seen_d   = seen_q | src_beat;
                end
            end

            RECOVER: begin
                // Beats and triggers are deliberately not looked at here.
                if (rec_q == REC_W'(RECOVER_CYCLES - 1)) begin
                    state_d  = (|src_enable) ? RUN : IDLE;
                    period_d = '0;
                    seen_d   = '0;
                end else begin
                    rec_d = rec_q + REC_W'(1);
                end
            end

            LOCKOUT: begin
                // Only rst leaves this state.
            end

            default: state_d = IDLE;
        endcase
    end

    assign wdt_enable      = (state_q == RUN);
    assign subsys_reset    = (state_q == RECOVER) || (state_q == LOCKOUT);
    assign wdt_force_reset = (state_q == RECOVER) || (state_q == LOCKOUT);
    assign lockout         = (state_q == LOCKOUT);
    assign wdt_heartbeat   = hb_q;
    assign missing_mask    = missing_q;
    assign retry_count     = retry_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
module tb_watchdog_supervisor;

    localparam int NS = 4;
    localparam int CP = 8;
    localparam int RC = 4;
    localparam int MAXR = 3;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_REC  = 2;
    localparam int M_LOCK = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src_enable;
    logic [NS-1:0] src_beat;
    logic          wdt_triggered;
    logic          wdt_enable;
    logic          wdt_heartbeat;
    logic          wdt_force_reset;
    logic          subsys_reset;
    logic [NS-1:0] missing_mask;
    logic [1:0]    retry_count;
    logic          lockout;

    always #5 clk = ~clk;

    watchdog_supervisor #(
        .NUM_SRC(NS), .CHECK_PERIOD(CP), .RECOVER_CYCLES(RC), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .src_enable(src_enable), .src_beat(src_beat),
        .wdt_triggered(wdt_triggered), .wdt_enable(wdt_enable),
        .wdt_heartbeat(wdt_heartbeat), .wdt_force_reset(wdt_force_reset),
        .subsys_reset(subsys_reset), .missing_mask(missing_mask),
        .retry_count(retry_count), .lockout(lockout)
    );

    typedef struct packed {
        logic          en;
        logic          hb;
        logic          frc;
        logic          sub;
        logic          lck;
        logic [NS-1:0] miss;
        logic [1:0]    rc;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   total = 0;
    int   bad   = 0;

    // Reference model. A window is kept as the list of beat vectors seen so
    // far, and the window position is a plain cycle index.
    int            m_mode;
    int            m_pos;
    logic [NS-1:0] m_win[$];
    int            m_rec_left;
    int            m_retries;
    int            m_streak;
    logic [NS-1:0] m_miss;
    logic          m_hb;

    task automatic model_step(input logic r, input logic [NS-1:0] e,
                              input logic [NS-1:0] b, input logic t);
        logic [NS-1:0] s;
        m_hb = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_pos = 0; m_win.delete(); m_rec_left = 0;
            m_retries = 0; m_streak = 0; m_miss = '0;
        end else if (m_mode == M_IDLE) begin
            if (e != 0) begin
                m_mode = M_RUN; m_pos = 0; m_win.delete();
            end
        end else if (m_mode == M_RUN) begin
            if (t) begin
                m_streak = 0;
                if (m_retries < MAXR) begin
                    m_retries++; m_mode = M_REC; m_rec_left = RC;
                end else begin
                    m_mode = M_LOCK;
                end
            end else if (e == 0) begin
                m_mode = M_IDLE;
            end else if (m_pos == CP - 1) begin
                s = '0;
                foreach (m_win[i]) s |= m_win[i];
                if ((s & e) == e) begin
                    m_hb = 1'b1; m_miss = '0;
`ifdef WDT_SUP_RETRY_DECAY_EN
                    m_streak++;
                    if (m_streak == 8) begin
                        m_streak = 0;
                        if (m_retries > 0) m_retries--;
                    end
`endif
                end else begin
                    m_miss = e & ~s;
                    m_streak = 0;
                end
                m_win.delete();
                m_win.push_back(b);
                m_pos = 0;
            end else begin
                m_win.push_back(b);
                m_pos++;
            end
        end else if (m_mode == M_REC) begin
            m_rec_left--;
            if (m_rec_left == 0) begin
                m_mode = (e != 0) ? M_RUN : M_IDLE;
                m_pos = 0; m_win.delete();
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.en   = (m_mode == M_RUN);
        o.hb   = m_hb;
        o.frc  = (m_mode == M_REC) || (m_mode == M_LOCK);
        o.sub  = (m_mode == M_REC) || (m_mode == M_LOCK);
        o.lck  = (m_mode == M_LOCK);
        o.miss = m_miss;
        o.rc   = 2'(m_retries);
        return o;
    endfunction

    task automatic drive(input logic r, input logic [NS-1:0] e,
                         input logic [NS-1:0] b, input logic t);
        rst = r; src_enable = e; src_beat = b; wdt_triggered = t;
        @(posedge clk);
        model_step(r, e, b, t);
        exp_q.push_back(model_obs());
        #1;
    endtask

    // Every source beats once per window, at window position 2.
    task automatic run_healthy(input int n, input logic [NS-1:0] mask);
        for (int k = 0; k < n; k++)
            drive(1'b0, 4'hF, (m_mode == M_RUN && m_pos == 2) ? mask : 4'h0, 1'b0);
    endtask

    // Monitor: all outputs are registered or decoded from state, so they are
    // sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {wdt_enable, wdt_heartbeat, wdt_force_reset, subsys_reset,
                         lockout, missing_mask, retry_count};
                total++;
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got en=%b hb=%b frc=%b sub=%b lck=%b miss=%b rc=%0d want en=%b hb=%b frc=%b sub=%b lck=%b miss=%b rc=%0d",
                             $time, mon_a.en, mon_a.hb, mon_a.frc, mon_a.sub, mon_a.lck, mon_a.miss, mon_a.rc,
                             mon_e.en, mon_e.hb, mon_e.frc, mon_e.sub, mon_e.lck, mon_e.miss, mon_e.rc);
                end
            end
        end
    end

    initial begin
        logic          r, t;
        logic [NS-1:0] e, b;
        m_mode = M_IDLE; m_pos = 0; m_rec_left = 0; m_retries = 0;
        m_streak = 0; m_miss = '0; m_hb = 1'b0;

        // Reset, then idle with beats that must be ignored.
        repeat (3) drive(1'b1, 4'h0, 4'h0, 1'b0);
        repeat (3) drive(1'b0, 4'h0, 4'($urandom), 1'b0);

        // Healthy windows, then source 2 silent for one window, then recovery.
        run_healthy(40, 4'hF);
        run_healthy(CP, 4'b1011);
        run_healthy(24, 4'hF);

        // Three recoveries, then a fourth trigger reaches lockout.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'hF, 4'h0, 1'b1);
            run_healthy(12, 4'hF);
        end
        drive(1'b0, 4'hF, 4'h0, 1'b1);
        repeat (20) drive(1'b0, 4'hF, 4'($urandom), 1'($urandom));
        repeat (2) drive(1'b1, 4'hF, 4'h0, 1'b0);

        // Beat only on the window-end cycle, coincident with a trigger.
        for (int k = 0; k < 20 && !(m_mode == M_RUN && m_pos == CP - 1); k++)
            drive(1'b0, 4'hF, 4'h0, 1'b0);
        drive(1'b0, 4'hF, 4'hF, 1'b1);
        run_healthy(12, 4'hF);

        // Two recoveries, then a long healthy run (decay case).
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        run_healthy(3, 4'hF);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 4'hF, 4'h0, 1'b1);
            run_healthy(12, 4'hF);
        end
        run_healthy(80, 4'hF);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0)      e = 4'h0;
            else if ($urandom_range(0, 9) == 0)  e = 4'($urandom);
            else                                 e = 4'hF;
            b = 4'($urandom) & 4'($urandom);
            t = ($urandom_range(0, 39) == 0);
            drive(r, e, b, t);
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watchdog_supervisor.md
WATCHDOG_SUPERVISOR -- requirements
Module: watchdog_supervisor

Interface
REQ-001 Parameter NUM_SRC, default 4, number of heartbeat requesters (2..8).
REQ-002 Parameter CHECK_PERIOD, default 1000, window length in clk cycles (>=4).
REQ-003 Parameter RECOVER_CYCLES, default 16, subsystem reset pulse length in cycles (>=1).
REQ-004 Parameter MAX_RETRIES, default 3, recoveries permitted before lockout (1..3).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 src_enable  in  NUM_SRC  per-requester participation mask.
REQ-008 src_beat  in  NUM_SRC  per-requester heartbeat; one-cycle pulses or held levels both count.
REQ-009 wdt_triggered  in  1  watchdog expiry flag from the downstream watchdog timer.
REQ-010 wdt_enable  out  1  enable to the watchdog timer.
REQ-011 wdt_heartbeat  out  1  one-cycle aggregated heartbeat to the watchdog timer.
REQ-012 wdt_force_reset  out  1  force-reset request to the watchdog timer.
REQ-013 subsys_reset  out  1  reset to the supervised AM datapath.
REQ-014 missing_mask  out  NUM_SRC  enabled sources absent in the last completed window.
REQ-015 retry_count  out  2  recoveries performed since rst.
REQ-016 lockout  out  1  permanent fault indication.

Function
REQ-017 FSM states shall be IDLE, RUN, RECOVER and LOCKOUT.
REQ-018 In IDLE, wdt_enable=0; the FSM shall enter RUN on the first cycle src_enable!=0, with period counter and seen mask cleared.
REQ-019 In RUN, wdt_enable=1; seen mask bit i shall set whenever src_beat[i]=1, and remain set until window end.
REQ-020 Period counter shall count 0..CHECK_PERIOD-1 and wrap; the wrap cycle is the window end.
REQ-021 At window end, if (seen & src_enable)==src_enable, wdt_heartbeat shall pulse high in the next cycle for exactly one cycle and missing_mask shall clear.
REQ-022 At window end otherwise, no heartbeat shall be issued and missing_mask shall load src_enable & ~seen.
REQ-023 seen shall clear at window end; a src_beat coincident with the window-end cycle shall count toward the next window.
REQ-024 In RUN, src_enable becoming 0 shall return the FSM to IDLE on the next cycle, with missing_mask preserved.
REQ-025 In RUN, wdt_triggered=1 with retry_count<MAX_RETRIES shall enter RECOVER and increment retry_count.
REQ-026 In RUN, wdt_triggered=1 with retry_count==MAX_RETRIES shall enter LOCKOUT.
REQ-027 wdt_triggered coincident with a window end: the trigger shall take priority and no heartbeat shall issue.
REQ-028 RECOVER shall hold subsys_reset=1, wdt_enable=0 and wdt_force_reset=1 for exactly RECOVER_CYCLES cycles.
REQ-029 On leaving RECOVER, the FSM shall return to RUN (or IDLE if src_enable==0) with counter and seen cleared; missing_mask shall hold.
REQ-030 src_beat and wdt_triggered shall be ignored in RECOVER.
REQ-031 LOCKOUT shall hold lockout=1, subsys_reset=1, wdt_force_reset=1 and wdt_enable=0; it shall be exited only by rst.
REQ-032 retry_count shall saturate and never wrap.

Reset
REQ-033 rst shall force, on the next edge: IDLE, counter=0, seen=0, missing_mask=0, retry_count=0, and all outputs 0.
REQ-034 rst asserted mid-RECOVER or in LOCKOUT shall abort immediately, with no residual subsys_reset cycles.

Configuration
REQ-035 With WDT_SUP_RETRY_DECAY_EN defined, 8 consecutive healthy windows (REQ-021) shall decrement retry_count by 1 if nonzero; any unhealthy window or trigger resets the streak.
REQ-036 Without WDT_SUP_RETRY_DECAY_EN, retry_count shall be cleared only by rst, and no streak counter shall be synthesised.

Verification (bench uses NUM_SRC=4, CHECK_PERIOD=8, RECOVER_CYCLES=4, MAX_RETRIES=3)
REQ-037 rst, then src_enable=4'b1111 with all four sources beating once per window -> wdt_heartbeat one-cycle pulse every 8 cycles; missing_mask=0.
REQ-038 src_enable=4'b1111, source 2 silent for one window -> no heartbeat for that window; missing_mask=4'b0100; heartbeat resumes after source 2 resumes.
REQ-039 wdt_triggered pulsed in RUN -> subsys_reset and wdt_force_reset high for exactly 4 cycles, retry_count=1, then RUN with counter at 0.
REQ-040 Four triggers without rst -> fourth trigger enters LOCKOUT, lockout=1 held indefinitely; retry_count=3; rst clears it to IDLE.
REQ-041 Beat on the window-end cycle only, with trigger on the same cycle -> no heartbeat issued; RECOVER entered.
REQ-042 With WDT_SUP_RETRY_DECAY_EN defined: retry_count=2, then 8 healthy windows -> retry_count=1; without the macro, retry_count stays 2.
